// File: rtl/csadd_pkg.sv
// Shared defaults for the pipelined carry-select adder and its slice geometry.
package csadd_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_BLK    = 4;
    localparam int unsigned DEF_STAGES = 2;

    // Bits added per pipeline stage.
    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    localparam int unsigned SLICE = slice_w(DEF_WIDTH, DEF_STAGES);

endpackage

// File: rtl/csadd_blk.sv
// Combinational BLK-bit carry-select block: both carry-in outcomes are formed
// up front and the late-arriving carry only drives the final select.
module csadd_blk #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK:0] w_sum0;
    logic [BLK:0] w_sum1;

    assign w_sum0 = {1'b0, a} + {1'b0, b};
    assign w_sum1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

    assign {cout, s} = cin ? w_sum1 : w_sum0;

endmodule

// File: rtl/pipe_csadd.sv
// Pipelined add/subtract: each stage adds one WIDTH/STAGES slice with a chain
// of carry-select blocks; the whole pipe freezes while the output is stalled.
module pipe_csadd
    import csadd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BLK    = DEF_BLK,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SLC  = slice_w(WIDTH, STAGES);
    localparam int unsigned NBLK = SLC / BLK;

    if (WIDTH % (BLK * STAGES) != 0) begin : g_bad_cfg
        $error("pipe_csadd: WIDTH must be a multiple of BLK*STAGES");
    end

    logic w_stall;
    logic w_msb_cin;
    logic w_ovf;
    logic w_zero;
    logic r_ovf;
    logic r_zero;

    genvar k, j;
    for (k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO = k * SLC;
        localparam int unsigned HI = LO + SLC;

        // Operand bits from LO upward, and sum bits completed through this stage.
        logic [WIDTH-LO-1:0] w_a;
        logic [WIDTH-LO-1:0] w_b;
        logic                w_cin;
        logic                w_vin;
        logic [NBLK:0]       w_cc;
        logic [SLC-1:0]      w_sl;
        logic [HI-1:0]       w_sum;

        logic                r_vld;
        logic [HI-1:0]       r_sum;
        logic                r_c;

        if (k == 0) begin : g_in
            assign w_a   = a;
            assign w_b   = sub ? ~b : b;
            assign w_cin = sub | cin;
            assign w_vin = in_valid;
            assign w_sum = w_sl;
        end else begin : g_mid
            assign w_a   = g_stg[k-1].g_fwd.r_a;
            assign w_b   = g_stg[k-1].g_fwd.r_b;
            assign w_cin = g_stg[k-1].r_c;
            assign w_vin = g_stg[k-1].r_vld;
            assign w_sum = {w_sl, g_stg[k-1].r_sum};
        end

        assign w_cc[0] = w_cin;
        for (j = 0; j < NBLK; j++) begin : g_blk
            csadd_blk #(
                .BLK (BLK)
            ) u_blk (
                .a    (w_a[j*BLK +: BLK]),
                .b    (w_b[j*BLK +: BLK]),
                .cin  (w_cc[j]),
                .s    (w_sl[j*BLK +: BLK]),
                .cout (w_cc[j+1])
            );
        end

        // Only the operand bits still to be added travel to the next stage.
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] r_a;
            logic [WIDTH-HI-1:0] r_b;

            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    r_a <= w_a[WIDTH-LO-1:SLC];
                    r_b <= w_b[WIDTH-LO-1:SLC];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_sum <= '0;
                r_c   <= 1'b0;
            end else if (!w_stall) begin
                r_vld <= w_vin;
                r_sum <= w_sum;
                r_c   <= w_cc[NBLK];
            end
        end
    end

    // Carry into the MSB recovered from the MSB operand and sum bits.
    assign w_msb_cin = g_stg[STAGES-1].w_a[SLC-1] ^ g_stg[STAGES-1].w_b[SLC-1]
                     ^ g_stg[STAGES-1].w_sum[WIDTH-1];
    assign w_ovf     = w_msb_cin ^ g_stg[STAGES-1].w_cc[NBLK];
    assign w_zero    = ~|g_stg[STAGES-1].w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign out_valid = g_stg[STAGES-1].r_vld;
    assign s         = g_stg[STAGES-1].r_sum;
    assign cout      = g_stg[STAGES-1].r_c;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;

endmodule

// File: tb/tb_pipe_csadd.sv
// Scoreboard bench for pipe_csadd: the driver queues expected results on each
// accepted transfer, an independent monitor checks every completed output.
module tb_pipe_csadd;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    res_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    pipe_csadd #(
        .WIDTH  (32),
        .BLK    (4),
        .STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference: plain wide addition, signed overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        logic [W-1:0] yy;
        logic [W:0]   t;
        res_t         r;
        yy     = sb ? ~y : y;
        t      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        r.s    = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        r.zero = (t[W-1:0] == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb, input logic ordy,
                         input res_t e, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (acc) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
    endtask

    task automatic send(input vec_t v);
        logic acc;
        for (int t = 0; t < 20; t++) begin
            drive(1'b1, v.a, v.b, v.cin, v.sub, 1'b1, v.e, acc);
            if (acc) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL send_timeout a=%0h b=%0h not accepted", v.a, v.b);
    endtask

    // Monitor: completion on out_valid && out_ready, hold check during stall.
    initial begin : monitor
        res_t got;
        res_t held;
        res_t e;
        logic pstall;
        pstall = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pstall = 1'b0;
            end else begin
                got = {s, cout, ovf, zero};
                if (pstall) check("stall_hold", 64'(got), 64'(held));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_output got=%0h expected=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 64'(got), 64'(e));
                    end
                end
                pstall = out_valid && !out_ready;
                held   = got;
            end
        end
    end

    vec_t dir[8];

    initial begin : driver
        logic   acc;
        int     idx;
        int     sent;
        int     cyc;
        logic   pend;
        vec_t   pv;

        // Hand-computed expectations: {s, cout, ovf, zero}.
        dir[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        dir[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        dir[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        dir[3] = '{32'hA3F5_C9D7, 32'h4B6E_89A2, 1'b1, 1'b0, '{32'hEF64_537A, 1'b0, 1'b0, 1'b0}};
        dir[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        dir[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        dir[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        dir[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'({s, cout, ovf, zero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Latency: result visible exactly two cycles after acceptance.
        send(dir[0]);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
        check("latency_1cyc_out_valid", 64'(out_valid), 64'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
        check("latency_2cyc_out_valid", 64'(out_valid), 64'd1);
        idle(2);

        for (int i = 1; i < 8; i++) send(dir[i]);
        idle(4);

        // Back-to-back with out_ready low for the first five cycles.
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            drive(1'b1, dir[idx].a, dir[idx].b, dir[idx].cin, dir[idx].sub,
                  (c >= 5), dir[idx].e, acc);
            if (c < 6) check("stall_in_ready", 64'(in_ready), (c < 2 || c >= 5) ? 64'd1 : 64'd0);
            if (acc) idx++;
        end
        idle(5);

        // Reset with two transactions in flight.
        drive(1'b1, dir[1].a, dir[1].b, dir[1].cin, dir[1].sub, 1'b0, dir[1].e, acc);
        drive(1'b1, dir[2].a, dir[2].b, dir[2].cin, dir[2].sub, 1'b0, dir[2].e, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("reset_flush_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        idle(6);
        check("in_ready_after_flush", 64'(in_ready), 64'd1);

        // Random traffic; a presented operand set is held until accepted.
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        pv   = dir[0];
        while (sent < 10000 && cyc < 40000) begin
            if (!pend && ($urandom_range(3) != 0)) begin
                pv.a   = $urandom;
                pv.b   = $urandom;
                pv.cin = 1'($urandom_range(1));
                pv.sub = 1'($urandom_range(1));
                if ($urandom_range(15) == 0) pv.b = pv.a;
                pv.e   = model(pv.a, pv.b, pv.cin, pv.sub);
                pend   = 1'b1;
            end
            drive(pend, pv.a, pv.b, pv.cin, pv.sub, ($urandom_range(3) != 0), pv.e, acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        if (sent < 10000) begin
            n_vec++;
            n_miss++;
            $display("FAIL random_budget sent=%0d required=10000", sent);
        end
        idle(8);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
